rf_multiport: RTL
=================

// Module: rf_multiport
// PURPOSE
//  Parametrised multi-port register file for the minicpu datapath; next
//  generation of the 2R/1W MIPS file. Adds N read / M write ports,
//  same-cycle write-to-read bypass and an async-reset array. Adds a
//  per-register pending-write scoreboard, so Decode detects RAW hazards
//  without a separate unit. Sits between Decode (reads/issue) and
//  Writeback (writes).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register specifier width; DEPTH = 2**ADDR_W
//  NRD       2   number of combinational read ports
//  NWR       2   number of write ports (port NWR-1 highest priority)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy
//  BYPASS    1   1: same-cycle write data forwarded to matching reads
// PORTS
//  WCLK      in   1            single clock, all state updates on posedge
//  RST_N     in   1            async active-low reset
//  RADDR     in   NRD*ADDR_W   read specifiers, port i at [i*ADDR_W +: ADDR_W]
//  RDATA     out  NRD*DATA_W   read data, port i at [i*DATA_W +: DATA_W]
//  RBUSY     out  NRD          1 = register on port i still has a pending write
//  WEN       in   NWR          write enables
//  WADDR     in   NWR*ADDR_W   write specifiers
//  WDATA     in   NWR*DATA_W   write data
//  ISS_EN    in   1            mark ISS_ADDR pending (instruction issued)
//  ISS_ADDR  in   ADDR_W       destination of issuing instruction
//  ISS_HAZ   out  1            ISS_EN & ISS_ADDR already pending (WAW)
// BEHAVIOUR
//  - Reset: RST_N low clears all DEPTH registers to 0 and all busy bits
//    at once, with no clock edge needed. RDATA then reads 0; RBUSY and
//    ISS_HAZ are 0. Reset asserted mid-write discards that write.
//  - Write: on posedge WCLK each port with WEN[j]=1 writes WDATA[j] to
//    RAM[WADDR[j]]. Latency is 1 cycle.
//  - Write collision: two ports writing the same address in one cycle ->
//    the highest port index wins.
//  - ZERO_REG=1: writes to address 0 are dropped. RDATA for address 0 is 0.
//  - Read: combinational. RDATA[i] = RAM[RADDR[i]] unless bypassed.
//  - Bypass: if BYPASS=1 and any WEN[j] has WADDR[j]==RADDR[i] (and the
//    address is not 0 under ZERO_REG), RDATA[i] = WDATA of the
//    highest-index matching port.
//  - BYPASS=0: reads return the pre-edge value until the next cycle.
//  - Scoreboard (busy[DEPTH]):
//    - ISS_EN sets busy[ISS_ADDR] on posedge.
//    - WEN[j] clears busy[WADDR[j]] on posedge.
//    - Set and clear of the same address in one cycle -> set wins (new
//      producer outstanding).
//    - busy[0] is held at 0 when ZERO_REG=1.
//  - RBUSY[i] = busy[RADDR[i]], cleared combinationally when BYPASS=1 and a
//    write to that address is present this cycle.
//  - ISS_HAZ is combinational and informational only. The set still
//    occurs; upstream is responsible for stalling.
//  - All arithmetic is unsigned. Address compares are full ADDR_W.
//    DEPTH wraps nowhere (every specifier is legal).
// STRUCTURE
//  - rf_defs.vh, included alongside mips.h: default DATA_W/ADDR_W,
//    port-slice macros, `RF_ZERO_ADDR.
//  - Sub-module rf_scoreboard (busy array, set/clear priority, RBUSY and
//    ISS_HAZ lookup).
//  - The data array, write-priority logic and bypass muxes stay in
//    rf_multiport, built from generate loops over NRD/NWR.
// TESTING
//  1. Reset: RST_N=0 between edges -> all RDATA=0 and RBUSY=0
//     immediately; r5 previously holding 0xDEADBEEF reads 0.
//  2. Write/read: WEN[0], WADDR=3, WDATA=0x1234 -> the same cycle reads
//     0x1234 via bypass; the next cycle reads 0x1234 from the array.
//     With BYPASS=0 the same cycle reads the old value 0.
//  3. Collision: port0 writes r7=0xAAAA and port1 writes r7=0x5555 ->
//     the bypass read and the later array read both return 0x5555.
//  4. r0: write r0=0xFFFFFFFF and issue r0 -> RDATA=0, RBUSY=0, ISS_HAZ=0.
//  5. Scoreboard: issue r9 -> RBUSY=1 next cycle. Issue r9 again ->
//     ISS_HAZ=1. Write r9=0x42 -> RBUSY=0 that cycle and after; data
//     reads 0x42.
//  6. Set/clear race: same cycle issue r4 and write r4=0x10 -> r4=0x10
//     and busy[4]=1 after the edge.

Source files
------------

// File: rtl/rf_multiport_pkg.sv
// Shared defaults for the multi-port register file slice.
// Purpose : default widths used by rf_multiport and rf_multiport_scoreboard.
// Ports   : none (package only).
package rf_multiport_pkg;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
endpackage

// File: rtl/rf_multiport_scoreboard.sv
// Per-register pending-write scoreboard.
// Purpose : tracks which registers have an issued-but-not-written producer,
//           so Decode can see RAW hazards (rbusy) and WAW issue (iss_haz).
// Ports   : clk, rst_n          clock / async active-low reset
//           raddr  [NRD*ADDR_W]  read specifiers to look up
//           rbusy  [NRD]         busy flag per read port
//           wen    [NWR]         write enables (clear busy)
//           waddr  [NWR*ADDR_W]  write specifiers
//           iss_en, iss_addr     issue request (sets busy)
//           iss_haz              issue target is already busy
module rf_multiport_scoreboard
    import rf_multiport_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  iss_haz
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Clears first, then the issue set, so a same-cycle set/clear leaves the
    // register busy: the new producer is still outstanding.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (wen[j]) busy_nxt[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (iss_en) busy_nxt[iss_addr] = 1'b1;
        if (ZERO_REG) busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // A write landing this cycle makes the value available through the
    // bypass, so the reader need not stall on it.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) begin
            rbusy[i] = busy[raddr[i*ADDR_W +: ADDR_W]];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wen[j] && waddr[j*ADDR_W +: ADDR_W] == raddr[i*ADDR_W +: ADDR_W])
                        rbusy[i] = 1'b0;
                end
            end
        end
    end

    assign iss_haz = iss_en & busy[iss_addr];
endmodule

// File: rtl/rf_multiport.sv
// Parametrised N-read / M-write register file with write-to-read bypass,
// async-reset array and pending-write scoreboard.
// Purpose : operand storage between Decode (reads, issue) and Writeback.
// Ports   : WCLK, RST_N         clock / async active-low reset
//           RADDR [NRD*ADDR_W]  read specifiers, port i at [i*ADDR_W +: ADDR_W]
//           RDATA [NRD*DATA_W]  combinational read data
//           RBUSY [NRD]         register on port i has a pending write
//           WEN/WADDR/WDATA     write ports, highest index wins a collision
//           ISS_EN, ISS_ADDR    mark destination pending
//           ISS_HAZ             issue target already pending (WAW)
module rf_multiport
    import rf_multiport_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  WCLK,
    input  logic                  RST_N,
    input  logic [NRD*ADDR_W-1:0] RADDR,
    output logic [NRD*DATA_W-1:0] RDATA,
    output logic [NRD-1:0]        RBUSY,
    input  logic [NWR-1:0]        WEN,
    input  logic [NWR*ADDR_W-1:0] WADDR,
    input  logic [NWR*DATA_W-1:0] WDATA,
    input  logic                  ISS_EN,
    input  logic [ADDR_W-1:0]     ISS_ADDR,
    output logic                  ISS_HAZ
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Ports are visited in ascending order so the highest-index port's
    // assignment is the one that lands on a collision.
    always_ff @(posedge WCLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (WEN[j] && !(ZERO_REG && WADDR[j*ADDR_W +: ADDR_W] == '0))
                    mem[WADDR[j*ADDR_W +: ADDR_W]] <= WDATA[j*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = RADDR[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (WEN[j] && WADDR[j*ADDR_W +: ADDR_W] == ra)
                        rd = WDATA[j*DATA_W +: DATA_W];
                end
            end
            // Also masks any forwarded write aimed at r0.
            if (ZERO_REG && ra == '0) rd = '0;
        end

        assign RDATA[i*DATA_W +: DATA_W] = rd;
    end

    rf_multiport_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (WCLK),
        .rst_n    (RST_N),
        .raddr    (RADDR),
        .rbusy    (RBUSY),
        .wen      (WEN),
        .waddr    (WADDR),
        .iss_en   (ISS_EN),
        .iss_addr (ISS_ADDR),
        .iss_haz  (ISS_HAZ)
    );
endmodule
